// File: rtl/v60_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : v60_bus_arbiter
//  Purpose  : Shares the single V60 external memory port between up to
//             N_MASTERS bus masters (0 = CPU, 1 = DMA, 2 = debug).
//             Round-robin arbitration, per-master bus lock for
//             read-modify-write sequences, and a ready timeout that turns
//             a hung access into a bus error.
//  Ports    : clk, rst_n              clock, asynchronous active-low reset
//             m_req/m_lock/m_wr       per-master request, lock, write enable
//             m_size/m_addr/m_wdata   per-master command, packed by master
//             m_rdata                 read data broadcast (= s_rdata)
//             m_ready/m_err           one-hot completion / bus-error pulses
//             s_req..s_wdata          memory-side command
//             s_rdata/s_ready         memory-side response
//             grant                   one-hot current owner
//             err_addr                address of the last timed-out access
//  Revision : 1.0 - initial release
// ============================================================================
module v60_bus_arbiter #(
    parameter int N_MASTERS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS-1:0]          m_lock,
    input  logic [N_MASTERS-1:0]          m_wr,
    input  logic [2*N_MASTERS-1:0]        m_size,
    input  logic [ADDR_W*N_MASTERS-1:0]   m_addr,
    input  logic [DATA_W*N_MASTERS-1:0]   m_wdata,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic [N_MASTERS-1:0]          m_err,
    output logic                          s_req,
    output logic                          s_wr,
    output logic [1:0]                    s_size,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    output logic [N_MASTERS-1:0]          grant,
    output logic [ADDR_W-1:0]             err_addr
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] C_LAST_INIT = IDX_W'(N_MASTERS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Per-master command slices unpacked for indexed access.
    logic [ADDR_W-1:0] w_addr_arr  [N_MASTERS];
    logic [DATA_W-1:0] w_wdata_arr [N_MASTERS];
    logic [1:0]        w_size_arr  [N_MASTERS];

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
        assign w_size_arr[gi]  = m_size[gi*2 +: 2];
    end

    state_t            state_q,    state_d;
    logic [IDX_W-1:0]  gidx_q,     gidx_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [IDX_W-1:0]  last_q,     last_d;
    logic              lock_vld_q, lock_vld_d;
    logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
    logic              wr_q,       wr_d;
    logic [1:0]        size_q,     size_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    // Round-robin search starting just after the last granted master.
    logic              w_rr_found;
    logic [IDX_W-1:0]  w_rr_idx;
    int                w_cand;

    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_cand     = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            w_cand = int'(last_q) + k;
            if (w_cand >= N_MASTERS) begin
                w_cand = w_cand - N_MASTERS;
            end
            if (!w_rr_found && m_req[IDX_W'(w_cand)]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = IDX_W'(w_cand);
            end
        end
    end

    // Lock is only effective while its owner keeps m_lock high.
    logic             w_lock_hold;
    logic             w_win;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_done;

    assign w_lock_hold = lock_vld_q && m_lock[lock_idx_q];

    always_comb begin
        state_d    = state_q;
        gidx_d     = gidx_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        wr_d       = wr_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_addr_d = err_addr_q;
        w_win      = 1'b0;
        w_win_idx  = '0;
        w_done     = 1'b0;
        s_req      = 1'b0;
        m_ready    = '0;
        m_err      = '0;
        grant      = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_lock_hold) begin
                    // Bus stays reserved for the lock owner even while it
                    // is not requesting.
                    grant[lock_idx_q] = 1'b1;
                    if (m_req[lock_idx_q]) begin
                        w_win     = 1'b1;
                        w_win_idx = lock_idx_q;
                    end
                end else begin
                    // Stale lock released here; normal arbitration proceeds
                    // in the same cycle.
                    lock_vld_d = 1'b0;
                    w_win      = w_rr_found;
                    w_win_idx  = w_rr_idx;
                end

                if (w_win) begin
                    state_d = ST_BUSY;
                    gidx_d  = w_win_idx;
                    cnt_d   = '0;
                    wr_d    = m_wr[w_win_idx];
                    size_d  = w_size_arr[w_win_idx];
                    addr_d  = w_addr_arr[w_win_idx];
                    wdata_d = w_wdata_arr[w_win_idx];
                end
            end

            ST_BUSY: begin
                grant[gidx_q] = 1'b1;
                if (cnt_q == C_TIMEOUT) begin
                    // Error cycle: command withdrawn, s_ready ignored.
                    m_ready[gidx_q] = 1'b1;
                    m_err[gidx_q]   = 1'b1;
                    err_addr_d      = addr_q;
                    w_done          = 1'b1;
                end else begin
                    s_req = 1'b1;
                    if (s_ready) begin
                        m_ready[gidx_q] = 1'b1;
                        w_done          = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                if (w_done) begin
                    state_d    = ST_IDLE;
                    last_d     = gidx_q;
                    lock_vld_d = m_lock[gidx_q];
                    lock_idx_d = gidx_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gidx_q     <= '0;
            cnt_q      <= '0;
            last_q     <= C_LAST_INIT;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            wr_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            gidx_q     <= gidx_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign m_rdata  = s_rdata;
    assign s_wr     = wr_q;
    assign s_size   = size_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign err_addr = err_addr_q;

endmodule
`default_nettype wire
